// File: rtl/sdram_pkg.sv
// Shared SDRAM-side definitions: bus widths, arbiter state encoding and
// arbitration mode constants used by the arbiter and its pick logic.
package sdram_pkg;

  localparam int SDRAM_ADDR_W = 25;
  localparam int SDRAM_DATA_W = 32;
  localparam int SDRAM_MASK_W = 4;

  // Arbitration modes selected by the PRIO parameter.
  localparam int PRIO_RR    = 0;
  localparam int PRIO_FIXED = 1;

  // Arbiter transaction state.
  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_BUSY  = 2'd1,
    ARB_DRAIN = 2'd2
  } arb_state_t;

endpackage

// File: rtl/sdram_arb_pick2.sv
// Two-requester winner selection. Purely combinational.
// In round-robin mode a tie goes to the port that did not win last.
// In fixed-priority mode a tie goes to port 0 unless the starvation
// limit has been reached, in which case port 1 wins.
module arb_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  input  logic       prio,
  input  logic       starve_hit,
  output logic       gnt_valid,
  output logic       gnt_idx
);

  // Winner selection for a single requester or a tie.
  // NOTE: every output of an always_comb gets a default first so that no path leaves it unassigned, which would infer a latch.
  always_comb begin
    gnt_valid = |req;
    gnt_idx   = 1'b0;
    case (req)
      2'b01:   gnt_idx = 1'b0;
      2'b10:   gnt_idx = 1'b1;
      2'b11:   gnt_idx = prio ? starve_hit : ~last;
      default: gnt_idx = 1'b0;
    endcase
  end

endmodule

// File: rtl/sdram_arb.sv
// Two-port request arbiter in front of the SDRAM controller. Port 0 is the
// CPU bus, port 1 the video/DMA bus. One request is latched at a time and
// forwarded on the master port; the completion pulse and read data are
// routed back to the port that issued it. Every output is registered.
module sdram_arb
  import sdram_pkg::*;
#(
  parameter int ADDR_W     = SDRAM_ADDR_W,
  parameter int PRIO       = PRIO_RR,
  parameter int STARVE_MAX = 8
) (
  input  logic                    clk,
  input  logic                    resetn,

  input  logic                    p0_valid,
  input  logic [ADDR_W-1:0]       p0_addr,
  input  logic [SDRAM_DATA_W-1:0] p0_din,
  input  logic [SDRAM_MASK_W-1:0] p0_wmask,
  output logic [SDRAM_DATA_W-1:0] p0_dout,
  output logic                    p0_ready,

  input  logic                    p1_valid,
  input  logic [ADDR_W-1:0]       p1_addr,
  input  logic [SDRAM_DATA_W-1:0] p1_din,
  input  logic [SDRAM_MASK_W-1:0] p1_wmask,
  output logic [SDRAM_DATA_W-1:0] p1_dout,
  output logic                    p1_ready,

  output logic                    m_valid,
  output logic [ADDR_W-1:0]       m_addr,
  output logic [SDRAM_DATA_W-1:0] m_din,
  output logic [SDRAM_MASK_W-1:0] m_wmask,
  input  logic [SDRAM_DATA_W-1:0] m_dout,
  input  logic                    m_ready
);

  // Counter must be able to hold STARVE_MAX itself.
  localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);
  localparam logic             PRIO_BIT   = (PRIO == PRIO_FIXED);

  arb_state_t r_state;
  arb_state_t w_state_nxt;

  logic w_gnt_valid;
  logic w_gnt_idx;
  logic w_starve_hit;
  logic w_take;   // a request is latched this cycle
  logic w_done;   // the controller completes this cycle

  logic             r_grant;
  logic             r_last;
  logic [CNT_W-1:0] r_starve_cnt;

  logic                    r_m_valid;
  logic [ADDR_W-1:0]       r_m_addr;
  logic [SDRAM_DATA_W-1:0] r_m_din;
  logic [SDRAM_MASK_W-1:0] r_m_wmask;

  logic                    r_p0_ready;
  logic                    r_p1_ready;
  logic [SDRAM_DATA_W-1:0] r_p0_dout;
  logic [SDRAM_DATA_W-1:0] r_p1_dout;

  assign w_starve_hit = (r_starve_cnt == STARVE_LIM);

  arb_pick2 u_pick (
    .req        ({p1_valid, p0_valid}),
    .last       (r_last),
    .prio       (PRIO_BIT),
    .starve_hit (w_starve_hit),
    .gnt_valid  (w_gnt_valid),
    .gnt_idx    (w_gnt_idx)
  );

  // State register; synchronous active-low reset abandons any transaction.
  // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values and simulation matches hardware.
  always_ff @(posedge clk) begin
    if (!resetn) r_state <= ARB_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Next-state decode plus the latch/complete strobes for the datapath.
  // Requests are only looked at in IDLE, so a valid still held during
  // DRAIN cannot start a second transaction; m_ready only counts in BUSY.
  always_comb begin
    w_state_nxt = r_state;
    w_take      = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      ARB_IDLE: begin
        if (w_gnt_valid) begin
          w_take      = 1'b1;
          w_state_nxt = ARB_BUSY;
        end
      end
      ARB_BUSY: begin
        if (m_ready) begin
          w_done      = 1'b1;
          w_state_nxt = ARB_DRAIN;
        end
      end
      ARB_DRAIN: w_state_nxt = ARB_IDLE;
      default:   w_state_nxt = ARB_IDLE;
    endcase
  end

  // Latch the winning request onto the master port and hold it until completion.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_m_valid <= 1'b0;
      r_m_addr  <= '0;
      r_m_din   <= '0;
      r_m_wmask <= '0;
      r_grant   <= 1'b0;
      r_last    <= 1'b1;
    end else if (w_take) begin
      r_m_valid <= 1'b1;
      r_m_addr  <= w_gnt_idx ? p1_addr  : p0_addr;
      r_m_din   <= w_gnt_idx ? p1_din   : p0_din;
      r_m_wmask <= w_gnt_idx ? p1_wmask : p0_wmask;
      r_grant   <= w_gnt_idx;
      r_last    <= w_gnt_idx;
    end else if (w_done) begin
      r_m_valid <= 1'b0;
    end
  end

  // Count port-0 grants that bypass a waiting port 1; any port-1 grant clears it.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_starve_cnt <= '0;
    end else if (w_take && PRIO_BIT) begin
      if (w_gnt_idx)     r_starve_cnt <= '0;
      else if (p1_valid) r_starve_cnt <= r_starve_cnt + CNT_W'(1);
    end
  end

  // Route the completion back: one-cycle ready pulse, read data held until
  // that port's next completion.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_p0_ready <= 1'b0;
      r_p1_ready <= 1'b0;
      r_p0_dout  <= '0;
      r_p1_dout  <= '0;
    end else begin
      r_p0_ready <= 1'b0;
      r_p1_ready <= 1'b0;
      if (w_done) begin
        if (r_grant) begin
          r_p1_ready <= 1'b1;
          r_p1_dout  <= m_dout;
        end else begin
          r_p0_ready <= 1'b1;
          r_p0_dout  <= m_dout;
        end
      end
    end
  end

  assign m_valid  = r_m_valid;
  assign m_addr   = r_m_addr;
  assign m_din    = r_m_din;
  assign m_wmask  = r_m_wmask;
  assign p0_ready = r_p0_ready;
  assign p1_ready = r_p1_ready;
  assign p0_dout  = r_p0_dout;
  assign p1_dout  = r_p1_dout;

endmodule

// File: tb/tb_sdram_arb.sv
// Directed bench for sdram_arb. Two instances share the port-side stimulus:
// index 0 is round-robin, index 1 is fixed priority with STARVE_MAX=2.
// Each instance has its own controller model that answers two cycles after
// m_valid rises, returning a word from a small fixed address table.
module tb_sdram_arb;

  logic clk = 1'b0;
  logic resetn;

  logic        p0_valid, p1_valid;
  logic [24:0] p0_addr, p1_addr;
  logic [31:0] p0_din, p1_din;
  logic [3:0]  p0_wmask, p1_wmask;

  logic [31:0] p0_dout [2];
  logic [31:0] p1_dout [2];
  logic        p0_ready[2];
  logic        p1_ready[2];
  logic        m_valid [2];
  logic [24:0] m_addr  [2];
  logic [31:0] m_din   [2];
  logic [3:0]  m_wmask [2];
  logic [31:0] m_dout  [2];
  logic        m_ready [2];

  logic inject[2];

  int n_checks = 0;
  int n_fail   = 0;

  // monitor statistics
  int          cyc = 0;
  int          gcnt   [2];
  logic [60:0] fwd    [2][16];
  int          gap    [2][16];
  int          last_rdy[2];
  logic        prev_mv[2];
  int          rdy_cnt[2][2];
  int          run    [2][2];
  int          maxrun [2][2];
  int          mcnt   [2];

  sdram_arb #(.ADDR_W(25), .PRIO(0), .STARVE_MAX(8)) u_rr (
    .clk(clk), .resetn(resetn),
    .p0_valid(p0_valid), .p0_addr(p0_addr), .p0_din(p0_din), .p0_wmask(p0_wmask),
    .p0_dout(p0_dout[0]), .p0_ready(p0_ready[0]),
    .p1_valid(p1_valid), .p1_addr(p1_addr), .p1_din(p1_din), .p1_wmask(p1_wmask),
    .p1_dout(p1_dout[0]), .p1_ready(p1_ready[0]),
    .m_valid(m_valid[0]), .m_addr(m_addr[0]), .m_din(m_din[0]), .m_wmask(m_wmask[0]),
    .m_dout(m_dout[0]), .m_ready(m_ready[0])
  );

  sdram_arb #(.ADDR_W(25), .PRIO(1), .STARVE_MAX(2)) u_fp (
    .clk(clk), .resetn(resetn),
    .p0_valid(p0_valid), .p0_addr(p0_addr), .p0_din(p0_din), .p0_wmask(p0_wmask),
    .p0_dout(p0_dout[1]), .p0_ready(p0_ready[1]),
    .p1_valid(p1_valid), .p1_addr(p1_addr), .p1_din(p1_din), .p1_wmask(p1_wmask),
    .p1_dout(p1_dout[1]), .p1_ready(p1_ready[1]),
    .m_valid(m_valid[1]), .m_addr(m_addr[1]), .m_din(m_din[1]), .m_wmask(m_wmask[1]),
    .m_dout(m_dout[1]), .m_ready(m_ready[1])
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mem_rd(input logic [24:0] a);
    case (a)
      25'h000100: return 32'hDEADBEEF;
      25'h000200: return 32'h0A0A0A0A;
      25'h000300: return 32'h0B0B0B0B;
      default:    return 32'h0;
    endcase
  endfunction

  function automatic logic [127:0] outs(input int d);
    return {m_valid[d], m_addr[d], m_din[d], m_wmask[d],
            p0_ready[d], p1_ready[d], p0_dout[d], p1_dout[d]};
  endfunction

  // Monitor then controller model, once per instance, away from the active edge.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (m_valid[d] && !prev_mv[d]) begin
        if (gcnt[d] < 16) begin
          fwd[d][gcnt[d]] = {m_addr[d], m_din[d], m_wmask[d]};
          gap[d][gcnt[d]] = cyc - last_rdy[d];
        end
        gcnt[d]++;
      end
      prev_mv[d] = m_valid[d];
      for (int p = 0; p < 2; p++) begin
        if ((p == 1) ? p1_ready[d] : p0_ready[d]) begin
          if (run[d][p] == 0) rdy_cnt[d][p]++;
          run[d][p]++;
          if (run[d][p] > maxrun[d][p]) maxrun[d][p] = run[d][p];
        end else begin
          run[d][p] = 0;
        end
      end
      if (!resetn) begin
        mcnt[d]    = 0;
        m_ready[d] = 1'b0;
        m_dout[d]  = 32'h0;
      end else begin
        m_ready[d] = inject[d];
        if (m_valid[d] && !inject[d]) begin
          mcnt[d]++;
          if (mcnt[d] == 2) begin
            m_ready[d]  = 1'b1;
            m_dout[d]   = mem_rd(m_addr[d]);
            last_rdy[d] = cyc;
            mcnt[d]     = 0;
          end
        end else begin
          mcnt[d] = 0;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clear_stats();
    for (int d = 0; d < 2; d++) begin
      gcnt[d]     = 0;
      last_rdy[d] = -100;
      for (int p = 0; p < 2; p++) begin
        rdy_cnt[d][p] = 0;
        maxrun[d][p]  = 0;
      end
    end
  endtask

  task automatic wait_rises(input int n, input string tag);
    int k = 0;
    while (!(gcnt[0] >= n && gcnt[1] >= n) && k < 300) begin
      @(negedge clk); #1;
      k++;
    end
    check(tag, (gcnt[0] >= n && gcnt[1] >= n), 1);
  endtask

  // port: 0/1; waits for that port's ready on the round-robin instance
  task automatic wait_ready(input int port, input string tag);
    int k = 0;
    while (!((port == 1) ? p1_ready[0] : p0_ready[0]) && k < 100) begin
      @(negedge clk); #1;
      k++;
    end
    check(tag, ((port == 1) ? p1_ready[0] : p0_ready[0]), 1);
  endtask

  initial begin
    resetn = 1'b0;
    p0_valid = 0; p1_valid = 0;
    p0_addr = '0; p1_addr = '0; p0_din = '0; p1_din = '0; p0_wmask = '0; p1_wmask = '0;
    for (int d = 0; d < 2; d++) begin
      inject[d] = 1'b0; prev_mv[d] = 1'b0; mcnt[d] = 0;
      run[d][0] = 0; run[d][1] = 0;
    end
    clear_stats();

    repeat (3) @(posedge clk);
    #1;
    check("rst_rr_outs", outs(0), '0);
    check("rst_fp_outs", outs(1), '0);
    resetn = 1'b1;

    // Both ports requesting continuously for six transactions.
    clear_stats();
    p0_addr = 25'h200; p0_din = 32'h11111111; p0_wmask = 4'hF;
    p1_addr = 25'h300; p1_din = 32'h22222222; p1_wmask = 4'h3;
    p0_valid = 1; p1_valid = 1;
    wait_rises(6, "t2_wait");
    p0_valid = 0; p1_valid = 0;
    repeat (8) @(posedge clk);
    #1;
    for (int i = 0; i < 6; i++) begin
      logic [60:0] e0, e1;
      e0 = {25'h200, 32'h11111111, 4'hF};
      e1 = {25'h300, 32'h22222222, 4'h3};
      check($sformatf("t2_rr_fwd%0d", i), fwd[0][i], ((i % 2) == 1) ? e1 : e0);
      check($sformatf("t2_fp_fwd%0d", i), fwd[1][i], ((i % 3) == 2) ? e1 : e0);
    end
    for (int i = 1; i < 6; i++)
      check($sformatf("t2_gap%0d_ge3", i), (gap[0][i] >= 3), 1);
    check("t2_rr_nrise", gcnt[0], 6);
    check("t2_rr_p0_cnt", rdy_cnt[0][0], 3);
    check("t2_rr_p1_cnt", rdy_cnt[0][1], 3);
    check("t2_fp_p0_cnt", rdy_cnt[1][0], 4);
    check("t2_fp_p1_cnt", rdy_cnt[1][1], 2);
    check("t2_rr_pulse_w", {maxrun[0][0], maxrun[0][1]}, {32'd1, 32'd1});
    check("t2_rr_p0_dout", p0_dout[0], 32'h0A0A0A0A);
    check("t2_rr_p1_dout", p1_dout[0], 32'h0B0B0B0B);
    check("t2_fp_p1_dout", p1_dout[1], 32'h0B0B0B0B);

    // Single read on port 0; valid held through the DRAIN cycle.
    clear_stats();
    p0_addr = 25'h100; p0_din = 32'h0; p0_wmask = 4'h0;
    p0_valid = 1;
    wait_ready(0, "t1_p0_ready_seen");
    check("t1_p0_dout_at_ready", p0_dout[0], 32'hDEADBEEF);
    @(posedge clk); #1;
    p0_valid = 0;
    repeat (8) @(posedge clk);
    #1;
    check("t1_nrise", gcnt[0], 1);
    check("t1_fwd", fwd[0][0], {25'h100, 32'h0, 4'h0});
    check("t1_p0_cnt", rdy_cnt[0][0], 1);
    check("t1_p1_cnt", rdy_cnt[0][1], 0);
    check("t1_p0_pulse_w", maxrun[0][0], 1);
    check("t1_p0_dout_hold", p0_dout[0], 32'hDEADBEEF);
    check("t1_p1_dout_hold", p1_dout[0], 32'h0B0B0B0B);
    check("t1_fp_p0_dout", p0_dout[1], 32'hDEADBEEF);

    // Stray m_ready while idle, then a normal port-1 write.
    clear_stats();
    inject[0] = 1; inject[1] = 1;
    @(posedge clk); #1;
    inject[0] = 0; inject[1] = 0;
    repeat (4) @(posedge clk);
    #1;
    check("t3_idle_rdy_ignored",
          {gcnt[0], gcnt[1], rdy_cnt[0][0], rdy_cnt[0][1], rdy_cnt[1][0], rdy_cnt[1][1]}, '0);
    p1_addr = 25'h300; p1_din = 32'h33333333; p1_wmask = 4'hC;
    p1_valid = 1;
    wait_ready(1, "t3_p1_ready_seen");
    @(posedge clk); #1;
    p1_valid = 0;
    repeat (6) @(posedge clk);
    #1;
    check("t3_fwd", fwd[0][0], {25'h300, 32'h33333333, 4'hC});
    check("t3_p1_cnt", rdy_cnt[0][1], 1);
    check("t3_p0_dout_hold", p0_dout[0], 32'hDEADBEEF);

    // Reset while BUSY, then a tie right after release.
    clear_stats();
    p1_valid = 1;
    begin
      int k = 0;
      while (!m_valid[0] && k < 50) begin
        @(negedge clk); #1;
        k++;
      end
      check("t4_busy_seen", m_valid[0], 1);
    end
    resetn = 1'b0;
    @(posedge clk); #1;
    check("t4_rst_rr_outs", outs(0), '0);
    check("t4_rst_fp_outs", outs(1), '0);
    p0_addr = 25'h200; p0_din = 32'h11111111; p0_wmask = 4'hF;
    p0_valid = 1;
    @(posedge clk); #1;
    clear_stats();
    resetn = 1'b1;
    wait_rises(2, "t4_wait");
    p0_valid = 0; p1_valid = 0;
    repeat (8) @(posedge clk);
    #1;
    check("t4_rr_first", fwd[0][0][60:36], 25'h200);
    check("t4_rr_second", fwd[0][1][60:36], 25'h300);
    check("t4_fp_first", fwd[1][0][60:36], 25'h200);
    check("t4_fp_second", fwd[1][1][60:36], 25'h200);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
